// File: rtl/param_pkg.sv
// Range-bound helpers and the increment/overflow/saturate arithmetic shared by
// the incrementer stage and anything that needs to model it.
package param_pkg;

    // Widest operand the helpers support. Operands must be strictly narrower.
    localparam int MAX_W = 32;

    typedef struct packed {
        logic             ovf;
        logic [MAX_W-1:0] data;
    } calc_t;

    function automatic longint umax(input int width);
        return (64'sd1 <<< width) - 64'sd1;
    endfunction

    function automatic longint smin(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    function automatic longint smax(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // 64-bit signed math is exact for any legal increment, so it yields the
    // same answer as a WIDTH+2-bit signed sum.
    function automatic calc_t calc(input logic [MAX_W-1:0] operand, input int width,
                                   input int inc, input bit signed_in, input bit sat);
        longint op;
        longint exact;
        longint lo;
        longint hi;
        longint masked;
        calc_t  r;
        op = {32'b0, operand};
        op = op & umax(width);
        if (signed_in && (op > smax(width)))
            op = op - (64'sd1 <<< width);
        exact = op + longint'(inc);
        lo    = signed_in ? smin(width) : 64'sd0;
        hi    = signed_in ? smax(width) : umax(width);
        r.ovf = (exact < lo) || (exact > hi);
        if (sat && (exact < lo))
            exact = lo;
        else if (sat && (exact > hi))
            exact = hi;
        masked = exact & umax(width);
        r.data = masked[MAX_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/inc_pipe_if.sv
// Operand-in / result-out stream bundle for the incrementer stage.
// Handshake: a beat moves on a rising edge where valid && ready are both high;
// a producer holds data stable while valid is high and ready is low.
interface inc_pipe_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ovf, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ovf, out_valid
    );
endinterface

// File: rtl/inc_fifo2.sv
// Two-entry synchronous FIFO; head is always in h0 so the read port is a plain
// register output.
module inc_fifo2 #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [1:0]   occ
);
    logic [W-1:0] h0;
    logic [W-1:0] h1;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && (occ != 2'd2);
    assign do_pop  = pop && (occ != 2'd0);
    assign rdata   = h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= 2'd0;
            h0  <= '0;
            h1  <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (occ == 2'd0) h0 <= wdata;
                    else             h1 <= wdata;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    h0  <= h1;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        h0 <= wdata;
                    end else begin
                        h0 <= h1;
                        h1 <= wdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/inc_pipe.sv
// Registered, flow-controlled incrementer: adds INC to each accepted operand,
// flags/optionally clamps overflow, and buffers results in a 2-entry FIFO.
module inc_pipe
    import param_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int INC       = 1,
    parameter bit SIGNED_IN = 1'b0,
    parameter bit SAT       = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    inc_pipe_if.slave   bus,
    output logic [15:0] count
);
    logic [1:0]     occ;
    logic           accept;
    logic           xfer;
    calc_t          res;
    logic [WIDTH:0] wdata;
    logic [WIDTH:0] rdata;
    logic           calc_unused;

    // in_ready depends only on registered occupancy and rst, never on out_ready.
    assign bus.in_ready  = (occ != 2'd2) && !rst;
    assign bus.out_valid = (occ != 2'd0);
    assign accept        = bus.in_valid && bus.in_ready;
    assign xfer          = bus.out_valid && bus.out_ready && !rst;

    always_comb begin
        res = calc({{(MAX_W-WIDTH){1'b0}}, bus.in_data}, WIDTH, INC, SIGNED_IN, SAT);
    end

    assign wdata       = {res.ovf, res.data[WIDTH-1:0]};
    assign calc_unused = ^res.data[MAX_W-1:WIDTH];

    inc_fifo2 #(.W(WIDTH + 1)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (xfer),
        .wdata (wdata),
        .rdata (rdata),
        .occ   (occ)
    );

    assign bus.out_data = rdata[WIDTH-1:0];
    assign bus.out_ovf  = rdata[WIDTH];

    always_ff @(posedge clk) begin
        if (rst)       count <= 16'd0;
        else if (xfer) count <= count + 16'd1;
    end
endmodule

// File: tb/tb_inc_pipe.sv
// Drives six inc_pipe configurations in lockstep with one operand stream and
// checks results, flow control, counting and reset against hand-computed values.
module tb_inc_pipe;
    localparam int NCFG = 6;
    // cfg: 0 INC+1 U wrap, 1 INC+1 U sat, 2 INC-1 S wrap, 3 INC-1 S sat,
    //      4 INC-1 U wrap, 5 INC-1 U sat
    localparam logic [5:0] SGN_M = 6'b001100;
    localparam logic [5:0] SAT_M = 6'b101010;

    typedef struct {
        logic [3:0]  din;
        logic [23:0] exp_d;  // nibble per cfg, cfg0 leftmost
        logic [5:0]  exp_o;  // bit per cfg, cfg0 leftmost
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_data;
    logic        in_valid;
    logic        out_ready;
    logic        in_ready_a  [NCFG];
    logic [3:0]  out_data_a  [NCFG];
    logic        out_ovf_a   [NCFG];
    logic        out_valid_a [NCFG];
    logic [15:0] count_a     [NCFG];

    int n_cmp  = 0;
    int n_fail = 0;
    vec_t vec [7];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        inc_pipe_if #(.WIDTH(4)) bus ();
        assign bus.in_data   = in_data;
        assign bus.in_valid  = in_valid;
        assign bus.out_ready = out_ready;
        assign in_ready_a[g]  = bus.in_ready;
        assign out_data_a[g]  = bus.out_data;
        assign out_ovf_a[g]   = bus.out_ovf;
        assign out_valid_a[g] = bus.out_valid;

        inc_pipe #(
            .WIDTH     (4),
            .INC       ((g < 2) ? 1 : -1),
            .SIGNED_IN (SGN_M[g]),
            .SAT       (SAT_M[g])
        ) u_dut (
            .clk   (clk),
            .rst   (rst),
            .bus   (bus.slave),
            .count (count_a[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_valid(input string name, input logic exp);
        for (int g = 0; g < NCFG; g++)
            chk($sformatf("%s_valid_c%0d", name, g), 32'(out_valid_a[g]), 32'(exp));
    endtask

    task automatic chk_all_ready(input string name, input logic exp);
        for (int g = 0; g < NCFG; g++)
            chk($sformatf("%s_ready_c%0d", name, g), 32'(in_ready_a[g]), 32'(exp));
    endtask

    task automatic chk_all_count(input string name, input logic [15:0] exp);
        for (int g = 0; g < NCFG; g++)
            chk($sformatf("%s_count_c%0d", name, g), 32'(count_a[g]), 32'(exp));
    endtask

    // Head for operand x with INC of the cfg, no overflow in these sequences.
    task automatic chk_head(input string name, input logic [3:0] x);
        for (int g = 0; g < NCFG; g++) begin
            logic [3:0] e;
            e = (g < 2) ? x + 4'd1 : x - 4'd1;
            chk($sformatf("%s_data_c%0d", name, g), 32'(out_data_a[g]), 32'(e));
            chk($sformatf("%s_ovf_c%0d", name, g), 32'(out_ovf_a[g]), 32'd0);
        end
    endtask

    initial begin
        vec[0] = '{din: 4'hF, exp_d: 24'h0FEEEE, exp_o: 6'b110000};
        vec[1] = '{din: 4'h3, exp_d: 24'h442222, exp_o: 6'b000000};
        vec[2] = '{din: 4'h8, exp_d: 24'h997877, exp_o: 6'b001100};
        vec[3] = '{din: 4'h0, exp_d: 24'h11FFF0, exp_o: 6'b000011};
        vec[4] = '{din: 4'h7, exp_d: 24'h886666, exp_o: 6'b000000};
        vec[5] = '{din: 4'hE, exp_d: 24'hFFDDDD, exp_o: 6'b000000};
        vec[6] = '{din: 4'h1, exp_d: 24'h220000, exp_o: 6'b000000};

        // Reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 4'h0;
        tick(); tick();
        chk_all_ready("rst_hi", 1'b0);
        chk_all_valid("rst", 1'b0);
        chk_all_count("rst", 16'd0);
        for (int g = 0; g < NCFG; g++) begin
            chk($sformatf("rst_data_c%0d", g), 32'(out_data_a[g]), 32'd0);
            chk($sformatf("rst_ovf_c%0d", g), 32'(out_ovf_a[g]), 32'd0);
        end
        rst = 1'b0;
        #1;
        chk_all_ready("rst_lo", 1'b1);

        // Streaming vectors: one accept and one transfer per edge
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_data = vec[k].din; in_valid = 1'b1;
            tick();
            chk_all_valid($sformatf("v%0d", k), 1'b1);
            for (int g = 0; g < NCFG; g++) begin
                chk($sformatf("v%0d_data_c%0d", k, g), 32'(out_data_a[g]),
                    32'(vec[k].exp_d[23-4*g -: 4]));
                chk($sformatf("v%0d_ovf_c%0d", k, g), 32'(out_ovf_a[g]),
                    32'(vec[k].exp_o[5-g]));
            end
        end
        in_valid = 1'b0;
        tick();
        chk_all_valid("drain", 1'b0);
        chk_all_count("drain", 16'd7);

        // Clear count, then backpressure: 1,2,3 offered with consumer stalled
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h1;
        tick();
        chk_all_ready("bp1", 1'b1);
        in_data = 4'h2;
        tick();
        chk_all_ready("bp2", 1'b0);
        chk_head("bp2", 4'h1);
        in_data = 4'h3;
        tick();
        chk_all_ready("bp3", 1'b0);
        chk_head("bp3_hold", 4'h1);
        out_ready = 1'b1;
        tick();
        chk_all_ready("bp4", 1'b1);
        chk_head("bp4", 4'h2);
        tick();
        in_valid = 1'b0;
        chk_head("bp5", 4'h3);
        tick();
        chk_all_valid("bp6", 1'b0);
        chk_all_count("bp6", 16'd3);

        // Reset with the buffer full discards both entries
        out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h5;
        tick();
        in_data = 4'h6;
        tick();
        chk_all_ready("full", 1'b0);
        chk_all_valid("full", 1'b1);
        rst = 1'b1; out_ready = 1'b1;
        tick();
        chk_all_valid("mid_rst", 1'b0);
        chk_all_count("mid_rst", 16'd0);
        chk_all_ready("mid_rst", 1'b0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk_all_ready("post_rst", 1'b1);
        tick();
        chk_all_valid("no_stale", 1'b0);
        chk_all_count("no_stale", 16'd0);
        in_valid = 1'b1; in_data = 4'h9;
        tick();
        in_valid = 1'b0;
        chk_head("fresh", 4'h9);
        tick();
        chk_all_valid("fresh_drain", 1'b0);
        chk_all_count("fresh_drain", 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
